pwm_generator_bank: RTL and testbench

Downstream consumer of the SPI register file: takes the ten 8-bit configuration registers and drives the 8 output pins. Contains four independent 8-bit PWM generators, each with a 4-bit clock prescaler, double-buffered duty/divider settings updated only at period boundaries, and a per-pin output mux selecting static level or one of the four generators.

---
 rtl/pwm_generator_bank_if.sv | 32 +++
 rtl/pwm_generator_bank.sv | 105 ++++++++++
 tb/tb_pwm_generator_bank.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/pwm_generator_bank_if.sv
// Register-map and pin bundle between the SPI register file side and the PWM bank.
// The master side owns the configuration registers and observes the pins; the slave is the bank.
interface pwm_generator_bank_if;
    logic [7:0] reg_en_out;
    logic [7:0] reg_en_pwm_out;
    logic [7:0] reg_out_3_0_pwm_chanel;
    logic [7:0] reg_out_7_4_pwm_chanel;
    logic [7:0] reg_pwm_gen_0_duty_cycle;
    logic [7:0] reg_pwm_gen_1_duty_cycle;
    logic [7:0] reg_pwm_gen_2_duty_cycle;
    logic [7:0] reg_pwm_gen_3_duty_cycle;
    logic [7:0] reg_pwm_gen_1_0_frequency_divider;
    logic [7:0] reg_pwm_gen_3_2_frequency_divider;
    logic [7:0] pwm_out;
    logic [3:0] period_start;

    modport master (
        output reg_en_out, reg_en_pwm_out, reg_out_3_0_pwm_chanel, reg_out_7_4_pwm_chanel,
        output reg_pwm_gen_0_duty_cycle, reg_pwm_gen_1_duty_cycle,
        output reg_pwm_gen_2_duty_cycle, reg_pwm_gen_3_duty_cycle,
        output reg_pwm_gen_1_0_frequency_divider, reg_pwm_gen_3_2_frequency_divider,
        input  pwm_out, period_start
    );

    modport slave (
        input  reg_en_out, reg_en_pwm_out, reg_out_3_0_pwm_chanel, reg_out_7_4_pwm_chanel,
        input  reg_pwm_gen_0_duty_cycle, reg_pwm_gen_1_duty_cycle,
        input  reg_pwm_gen_2_duty_cycle, reg_pwm_gen_3_duty_cycle,
        input  reg_pwm_gen_1_0_frequency_divider, reg_pwm_gen_3_2_frequency_divider,
        output pwm_out, period_start
    );
endinterface

// File: rtl/pwm_generator_bank.sv
// Four prescaled 8-bit PWM generators with period-boundary shadowing of duty/divider,
// and a registered per-pin mux choosing low, static high, or one of the generators.
module pwm_generator_bank (
    input  logic                  clk,
    input  logic                  rst_n,
    pwm_generator_bank_if.slave   bus
);

    logic [3:0] presc_r    [4];
    logic [7:0] cnt_r      [4];
    logic [7:0] duty_sh_r  [4];
    logic [3:0] div_sh_r   [4];
    logic       load_pending_r;
    logic [7:0] pwm_out_r;
    logic [3:0] period_start_r;

    logic [7:0] duty_in_s  [4];
    logic [3:0] div_in_s   [4];
    logic [1:0] sel_s      [8];
    logic [3:0] tick_s;
    logic [3:0] wrap_s;
    logic [3:0] gen_s;
    logic [7:0] pin_s;

    // Unpack the register map, derive per-generator tick/wrap/level and the next pin values.
    always_comb begin
        duty_in_s[0] = bus.reg_pwm_gen_0_duty_cycle;
        duty_in_s[1] = bus.reg_pwm_gen_1_duty_cycle;
        duty_in_s[2] = bus.reg_pwm_gen_2_duty_cycle;
        duty_in_s[3] = bus.reg_pwm_gen_3_duty_cycle;
        div_in_s[0]  = bus.reg_pwm_gen_1_0_frequency_divider[3:0];
        div_in_s[1]  = bus.reg_pwm_gen_1_0_frequency_divider[7:4];
        div_in_s[2]  = bus.reg_pwm_gen_3_2_frequency_divider[3:0];
        div_in_s[3]  = bus.reg_pwm_gen_3_2_frequency_divider[7:4];
        tick_s = 4'h0;
        wrap_s = 4'h0;
        gen_s  = 4'h0;
        pin_s  = 8'h00;
        for (int n = 0; n < 4; n++) begin
            tick_s[n] = (presc_r[n] == div_sh_r[n]);
            wrap_s[n] = tick_s[n] && (cnt_r[n] == 8'd254);
            gen_s[n]  = (cnt_r[n] < duty_sh_r[n]);
        end
        for (int i = 0; i < 4; i++) begin
            sel_s[i]     = bus.reg_out_3_0_pwm_chanel[2*i +: 2];
            sel_s[i + 4] = bus.reg_out_7_4_pwm_chanel[2*i +: 2];
        end
        for (int i = 0; i < 8; i++) begin
            if (!bus.reg_en_out[i]) begin
                pin_s[i] = 1'b0;
            end else if (!bus.reg_en_pwm_out[i]) begin
                pin_s[i] = 1'b1;
            end else begin
                pin_s[i] = gen_s[sel_s[i]];
            end
        end
    end

    // Generator state, shadow registers and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int n = 0; n < 4; n++) begin
                presc_r[n]   <= 4'd0;
                cnt_r[n]     <= 8'd0;
                duty_sh_r[n] <= 8'd0;
                div_sh_r[n]  <= 4'd0;
            end
            load_pending_r <= 1'b1;
            pwm_out_r      <= 8'h00;
            period_start_r <= 4'h0;
        end else if (load_pending_r) begin
            // First cycle out of reset: pick up the live settings and start every period together.
            for (int n = 0; n < 4; n++) begin
                presc_r[n]   <= 4'd0;
                cnt_r[n]     <= 8'd0;
                duty_sh_r[n] <= duty_in_s[n];
                div_sh_r[n]  <= div_in_s[n];
            end
            load_pending_r <= 1'b0;
            pwm_out_r      <= pin_s;
            period_start_r <= 4'hF;
        end else begin
            for (int n = 0; n < 4; n++) begin
                if (wrap_s[n]) begin
                    presc_r[n]   <= 4'd0;
                    cnt_r[n]     <= 8'd0;
                    duty_sh_r[n] <= duty_in_s[n];
                    div_sh_r[n]  <= div_in_s[n];
                end else if (tick_s[n]) begin
                    presc_r[n]   <= 4'd0;
                    cnt_r[n]     <= cnt_r[n] + 8'd1;
                end else begin
                    presc_r[n]   <= presc_r[n] + 4'd1;
                end
            end
            load_pending_r <= 1'b0;
            pwm_out_r      <= pin_s;
            period_start_r <= wrap_s;
        end
    end

    assign bus.pwm_out      = pwm_out_r;
    assign bus.period_start = period_start_r;

endmodule

// File: tb/tb_pwm_generator_bank.sv
// Directed bench for pwm_generator_bank: period/duty measurements per generator plus a
// table of static mux vectors, all expectations hand-computed.
module tb_pwm_generator_bank;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    pwm_generator_bank_if bus ();

    pwm_generator_bank dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] en;
        logic [7:0] en_pwm;
        logic [7:0] sel30;
        logic [7:0] sel74;
        logic [7:0] exp_out;
    } mux_vec_t;

    mux_vec_t tbl [7];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic wait_start(input int gen, input int bound);
        int waited;
        waited = 0;
        do begin
            step();
            waited++;
        end while (!bus.period_start[gen] && waited < bound);
        check("period_start_timeout", int'(bus.period_start[gen]), 1);
    endtask

    // Count pin-high samples from just after one period_start until the next one.
    task automatic measure(input int pin, input int gen, input int maxc,
                           output int highs, output int len);
        highs = 0;
        len   = 0;
        do begin
            step();
            len++;
            if (bus.pwm_out[pin]) highs++;
        end while (!bus.period_start[gen] && len < maxc);
    endtask

    initial begin
        int highs;
        int len;
        int mism;

        vectors     = 0;
        miscompares = 0;
        tbl[0] = '{8'hF0, 8'h00, 8'h00, 8'h00, 8'hF0};
        tbl[1] = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF};
        tbl[2] = '{8'h00, 8'hFF, 8'hAA, 8'hAA, 8'h00};
        tbl[3] = '{8'hFF, 8'hFF, 8'hAA, 8'hAA, 8'hFF};
        tbl[4] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00};
        tbl[5] = '{8'hFF, 8'hFF, 8'hEE, 8'hBB, 8'hA5};
        tbl[6] = '{8'h3C, 8'h0F, 8'hFF, 8'hFF, 8'h30};

        rst_n = 1'b0;
        bus.reg_en_out = 8'h00;
        bus.reg_en_pwm_out = 8'h00;
        bus.reg_out_3_0_pwm_chanel = 8'h00;
        bus.reg_out_7_4_pwm_chanel = 8'h00;
        bus.reg_pwm_gen_0_duty_cycle = 8'd0;
        bus.reg_pwm_gen_1_duty_cycle = 8'd0;
        bus.reg_pwm_gen_2_duty_cycle = 8'd0;
        bus.reg_pwm_gen_3_duty_cycle = 8'd0;
        bus.reg_pwm_gen_1_0_frequency_divider = 8'h00;
        bus.reg_pwm_gen_3_2_frequency_divider = 8'h00;
        step();
        step();
        check("reset_pwm_out", int'(bus.pwm_out), 0);
        check("reset_period_start", int'(bus.period_start), 0);

        // gen0: div 0, duty 128 on pin 0
        bus.reg_pwm_gen_0_duty_cycle = 8'd128;
        bus.reg_en_out = 8'h01;
        bus.reg_en_pwm_out = 8'h01;
        rst_n = 1'b1;
        step();
        check("release_period_start_all", int'(bus.period_start), 15);
        step();
        check("period_start_single_cycle", int'(bus.period_start), 0);
        wait_start(0, 300);
        measure(0, 0, 300, highs, len);
        check("gen0_period_len", len, 255);
        check("gen0_high_128", highs, 128);
        measure(0, 0, 300, highs, len);
        check("gen0_period_len_2", len, 255);
        check("gen0_high_128_2", highs, 128);

        // gen1: div 3 (upper nibble), duty 64 on pin 5
        bus.reg_pwm_gen_1_duty_cycle = 8'd64;
        bus.reg_pwm_gen_1_0_frequency_divider = 8'h30;
        bus.reg_out_7_4_pwm_chanel = 8'h04;
        bus.reg_en_out = 8'h21;
        bus.reg_en_pwm_out = 8'h21;
        wait_start(1, 300);
        measure(5, 1, 1100, highs, len);
        check("gen1_period_len", len, 1020);
        check("gen1_high_256", highs, 256);

        // gen2 on pin 2: duty 0 then duty 255, two periods each
        bus.reg_out_3_0_pwm_chanel = 8'h20;
        bus.reg_en_out = 8'h25;
        bus.reg_en_pwm_out = 8'h25;
        wait_start(2, 300);
        for (int p = 0; p < 2; p++) begin
            measure(2, 2, 300, highs, len);
            check("gen2_duty0_len", len, 255);
            check("gen2_duty0_high", highs, 0);
        end
        bus.reg_pwm_gen_2_duty_cycle = 8'd255;
        wait_start(2, 300);
        for (int p = 0; p < 2; p++) begin
            measure(2, 2, 300, highs, len);
            check("gen2_duty255_len", len, 255);
            check("gen2_duty255_high", highs, 255);
        end

        // gen0 duty 128 -> 32 at cnt 50: current period unaffected
        wait_start(0, 300);
        highs = 0;
        for (int k = 1; k <= 255; k++) begin
            step();
            if (k == 50) bus.reg_pwm_gen_0_duty_cycle = 8'd32;
            if (bus.pwm_out[0]) highs++;
        end
        check("gen0_midperiod_keep_128", highs, 128);
        check("gen0_midperiod_wrap", int'(bus.period_start[0]), 1);
        measure(0, 0, 300, highs, len);
        check("gen0_next_len", len, 255);
        check("gen0_next_high_32", highs, 32);

        // static mux table (gen2 constant high, gen3 constant low)
        for (int v = 0; v < 7; v++) begin
            bus.reg_en_out = tbl[v].en;
            bus.reg_en_pwm_out = tbl[v].en_pwm;
            bus.reg_out_3_0_pwm_chanel = tbl[v].sel30;
            bus.reg_out_7_4_pwm_chanel = tbl[v].sel74;
            step();
            check($sformatf("mux_vec_%0d", v), int'(bus.pwm_out), int'(tbl[v].exp_out));
        end

        // pins 4-7 share gen3 with duty 100
        bus.reg_pwm_gen_3_duty_cycle = 8'd100;
        bus.reg_en_out = 8'hF0;
        bus.reg_en_pwm_out = 8'hF0;
        bus.reg_out_7_4_pwm_chanel = 8'hFF;
        wait_start(3, 300);
        highs = 0;
        mism = 0;
        for (int k = 0; k < 255; k++) begin
            step();
            if (bus.pwm_out[7:4] != 4'h0 && bus.pwm_out[7:4] != 4'hF) mism++;
            if (bus.pwm_out[4]) highs++;
        end
        check("gen3_pins_identical", mism, 0);
        check("gen3_high_100", highs, 100);
        check("gen3_wrap", int'(bus.period_start[3]), 1);

        // one-cycle reset mid-period
        bus.reg_en_out = 8'hF1;
        bus.reg_en_pwm_out = 8'hF1;
        bus.reg_out_3_0_pwm_chanel = 8'h00;
        wait_start(0, 300);
        for (int k = 0; k < 30; k++) step();
        rst_n = 1'b0;
        step();
        check("midreset_pwm_out", int'(bus.pwm_out), 0);
        check("midreset_period_start", int'(bus.period_start), 0);
        rst_n = 1'b1;
        step();
        check("midreset_release_start", int'(bus.period_start), 15);
        measure(0, 0, 300, highs, len);
        check("midreset_gen0_len", len, 255);
        check("midreset_gen0_high_32", highs, 32);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
